// File: rtl/noc_pkg.sv
// Shared NoC constants: packet geometry, direction codes and output-arbiter state encoding.
package noc_pkg;
  localparam int PACKETW = 55;
  localparam int DATAW   = 25;
  localparam int DIR_LSB = DATAW;
  localparam int DIR_W   = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_LOCAL = 3'd0,
    DIR_NORTH = 3'd1,
    DIR_EAST  = 3'd2,
    DIR_SOUTH = 3'd3,
    DIR_WEST  = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_BACKOFF  = 2'd2
  } arb_state_e;

  // The downstream router re-routes from scratch, so the direction field leaves as LOCAL.
  function automatic logic [PACKETW-1:0] clearDir(input logic [PACKETW-1:0] p);
    logic [PACKETW-1:0] r;
    r = p;
    r[DIR_LSB +: DIR_W] = '0;
    return r;
  endfunction
endpackage

// File: rtl/noc_output_arbiter_if.sv
// Upstream request/grant and downstream req/gnt signals of one router output link.
interface noc_output_arbiter_if
  import noc_pkg::*;
#(
  parameter int NPORTS = 5
);
  logic [NPORTS-1:0]         req_in;
  logic [NPORTS*PACKETW-1:0] pkt_in;
  logic [NPORTS-1:0]         gnt_in;
  logic                      full_dn;
  logic                      gnt_dn;
  logic                      req_dn;
  logic [PACKETW-1:0]        pkt_out;
  logic                      busy;

  modport slave (
    input  req_in, pkt_in, full_dn, gnt_dn,
    output gnt_in, req_dn, pkt_out, busy
  );

  modport master (
    output req_in, pkt_in, full_dn, gnt_dn,
    input  gnt_in, req_dn, pkt_out, busy
  );
endinterface

// File: rtl/noc_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at NPORTS.
module noc_rr_picker #(
  parameter int NPORTS = 5
) (
  input  logic [NPORTS-1:0] req,
  input  logic [2:0]        ptr,
  output logic [NPORTS-1:0] gnt,
  output logic [2:0]        idx,
  output logic              any
);
  logic [3:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NPORTS)) cand = cand - 4'(NPORTS);
      if (!any && req[cand[2:0]]) begin
        any = 1'b1;
        idx = cand[2:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int k = 0; k < NPORTS; k++) gnt[k] = any && (idx == 3'(k));
  end
endmodule

// File: rtl/noc_output_arbiter.sv
// One output link of a router: round-robin among input ports, then req/gnt downstream with retry.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int TIMEOUT = 16,
  parameter int TIMERW  = 5
) (
  input logic                  clk,
  input logic                  reset,
  noc_output_arbiter_if.slave  bus
);
  arb_state_e          state, stateNxt;
  logic [2:0]          rrPtr, rrPtrNxt;
  logic [TIMERW-1:0]   timer, timerNxt;
  logic [NPORTS-1:0]   gntIn, gntInNxt;
  logic                reqDn, reqDnNxt;
  logic [PACKETW-1:0]  pktOut, pktOutNxt, pktSel;
  logic [NPORTS-1:0]   pickGnt;
  logic [2:0]          pickIdx;
  logic                pickAny;

  noc_rr_picker #(.NPORTS(NPORTS)) picker (
    .req(bus.req_in), .ptr(rrPtr), .gnt(pickGnt), .idx(pickIdx), .any(pickAny)
  );

  always_comb begin
    pktSel = '0;
    for (int k = 0; k < NPORTS; k++)
      if (pickGnt[k]) pktSel = bus.pkt_in[k*PACKETW +: PACKETW];
  end

  always_comb begin
    stateNxt  = state;
    rrPtrNxt  = rrPtr;
    timerNxt  = timer;
    gntInNxt  = '0;
    reqDnNxt  = reqDn;
    pktOutNxt = pktOut;
    case (state)
      ST_IDLE: begin
        if (pickAny && !bus.full_dn) begin
          gntInNxt  = pickGnt;
          pktOutNxt = clearDir(pktSel);
          reqDnNxt  = 1'b1;
          rrPtrNxt  = (pickIdx == 3'(NPORTS-1)) ? 3'd0 : pickIdx + 3'd1;
          timerNxt  = '0;
          stateNxt  = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (bus.gnt_dn) begin
          reqDnNxt = 1'b0;
          stateNxt = ST_IDLE;
        end else if (TIMEOUT != 0 && timer == TIMERW'(TIMEOUT-1)) begin
          // Drop req for a cycle so the downstream arbiter sees a fresh request edge.
          reqDnNxt = 1'b0;
          timerNxt = '0;
          stateNxt = ST_BACKOFF;
        end else begin
          timerNxt = timer + TIMERW'(1);
        end
      end
      ST_BACKOFF: begin
        reqDnNxt = 1'b1;
        stateNxt = ST_WAIT_GNT;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      rrPtr  <= '0;
      timer  <= '0;
      gntIn  <= '0;
      reqDn  <= 1'b0;
      pktOut <= '0;
    end else begin
      state  <= stateNxt;
      rrPtr  <= rrPtrNxt;
      timer  <= timerNxt;
      gntIn  <= gntInNxt;
      reqDn  <= reqDnNxt;
      pktOut <= pktOutNxt;
    end
  end

  assign bus.gnt_in  = gntIn;
  assign bus.req_dn  = reqDn;
  assign bus.pkt_out = pktOut;
  assign bus.busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed and random checks of noc_output_arbiter against a cycle-level behavioural model.
module tb_noc_output_arbiter;
  localparam int NP = 5;
  localparam int PW = 55;
  localparam int DW = 25;
  localparam int TO = 4;

  logic clk;
  logic reset;
  noc_output_arbiter_if #(.NPORTS(NP)) bus();

  noc_output_arbiter #(.NPORTS(NP), .TIMEOUT(TO), .TIMERW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 = free, 1 = offering a packet downstream, 2 = one-cycle pause after timeout.
  int           mMode, mPtr, mHigh;
  logic [NP-1:0] mGnt;
  logic         mReq;
  logic [PW-1:0] mPkt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void resetModel();
    mMode = 0; mPtr = 0; mHigh = 0; mGnt = '0; mReq = 1'b0; mPkt = '0;
  endfunction

  task automatic modelEdge();
    int k;
    logic [PW-1:0] p;
    mGnt = '0;
    case (mMode)
      0: if (bus.req_in != 0 && !bus.full_dn) begin
        k = -1;
        for (int off = 0; off < NP; off++) begin
          int c;
          c = (mPtr + off) % NP;
          if (k < 0 && bus.req_in[c]) k = c;
        end
        mGnt  = NP'(1) << k;
        p     = bus.pkt_in[k*PW +: PW];
        p[DW+2 -: 3] = 3'b000;
        mPkt  = p;
        mReq  = 1'b1;
        mPtr  = (k + 1) % NP;
        mHigh = 1;
        mMode = 1;
      end
      1: if (bus.gnt_dn) begin
        mReq = 1'b0; mMode = 0;
      end else if (mHigh == TO) begin
        mReq = 1'b0; mMode = 2;
      end else begin
        mHigh++;
      end
      default: begin
        mReq = 1'b1; mHigh = 1; mMode = 1;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    chk("gnt_in",  64'(bus.gnt_in),  64'(mGnt));
    chk("req_dn",  64'(bus.req_dn),  64'(mReq));
    chk("pkt_out", 64'(bus.pkt_out), 64'(mPkt));
    chk("busy",    64'(bus.busy),    64'(mMode != 0));
  endtask

  task automatic idleInputs();
    bus.req_in = '0; bus.full_dn = 1'b0; bus.gnt_dn = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    #1 resetModel();
    idleInputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic randPkts();
    logic [63:0] r;
    for (int k = 0; k < NP; k++) begin
      r = {$urandom(), $urandom()};
      bus.pkt_in[k*PW +: PW] = r[PW-1:0];
    end
  endtask

  function automatic int onehotIdx(input logic [NP-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NP; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    logic [PW-1:0] ref0, held;
    int order[$];
    int lastCyc, cyc;
    logic [9:0] pat;

    reset = 1'b0;
    idleInputs();
    bus.pkt_in = '0;
    resetModel();
    #1;
    chk("rst_gnt",  64'(bus.gnt_in), 0);
    chk("rst_req",  64'(bus.req_dn), 0);
    chk("rst_pkt",  64'(bus.pkt_out), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single port, direction field cleared
    randPkts();
    bus.pkt_in[2*PW + DW +: 3] = 3'b010;
    ref0 = bus.pkt_in[2*PW +: PW];
    bus.req_in = 5'b00100;
    step();
    chk("sp_gnt", 64'(bus.gnt_in), 64'(5'b00100));
    chk("sp_dir", 64'(bus.pkt_out[DW+2 -: 3]), 0);
    ref0[DW+2 -: 3] = 3'b000;
    chk("sp_rest", 64'(bus.pkt_out), 64'(ref0));
    bus.req_in = '0;
    bus.gnt_dn = 1'b1;
    step();
    chk("sp_done", 64'(bus.req_dn), 0);
    bus.gnt_dn = 1'b0;
    step();

    // Fairness: all ports request, grant accepted immediately
    doReset();
    bus.req_in = 5'b11111;
    lastCyc = -2;
    for (int c = 0; c < 12; c++) begin
      randPkts();
      step();
      if (bus.gnt_in != 0) begin
        order.push_back(onehotIdx(bus.gnt_in));
        if (lastCyc >= 0) chk("fair_rate", 64'(c - lastCyc), 2);
        lastCyc = c;
      end
      bus.gnt_dn = bus.req_dn;
    end
    chk("fair_cnt", 64'(order.size()), 6);
    for (int i = 0; i < order.size(); i++) chk("fair_ord", 64'(order[i]), 64'(i % NP));

    // Wrap: pointer at 4, only ports 0/1 request
    doReset();
    bus.req_in = 5'b11111;
    for (int c = 0; c < 8; c++) begin
      step();
      bus.gnt_dn = bus.req_dn;
    end
    bus.req_in = 5'b00011;
    bus.gnt_dn = 1'b0;
    step();
    chk("wrap_p0", 64'(bus.gnt_in), 64'(5'b00001));
    bus.gnt_dn = 1'b1;
    step();
    bus.gnt_dn = 1'b0;
    step();
    chk("wrap_p1", 64'(bus.gnt_in), 64'(5'b00010));
    bus.gnt_dn = 1'b1;
    bus.req_in = '0;
    step();
    bus.gnt_dn = 1'b0;

    // Backpressure
    bus.full_dn = 1'b1;
    bus.req_in = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_gnt",  64'(bus.gnt_in), 0);
      chk("bp_req",  64'(bus.req_dn), 0);
      chk("bp_busy", 64'(bus.busy), 0);
    end
    bus.full_dn = 1'b0;
    step();
    chk("bp_go", 64'(bus.gnt_in), 64'(5'b01000));

    // Timeout / retry: req high 4, low 1, repeat, packet held
    bus.req_in = '0;
    held = bus.pkt_out;
    for (int c = 0; c < 10; c++) begin
      randPkts();
      bus.req_in = 5'($urandom());
      step();
      pat[c] = bus.req_dn;
      chk("to_hold", 64'(bus.pkt_out), 64'(held));
    end
    chk("to_pat", 64'(pat), 64'(10'b1011110111));
    bus.gnt_dn = 1'b1;
    step();
    chk("to_end", 64'(bus.busy), 0);
    bus.gnt_dn = 1'b0;

    // Reset during WAIT_GNT
    bus.req_in = 5'b10000;
    step();
    bus.req_in = '0;
    step();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mr_req", 64'(bus.req_dn), 0);
    chk("mr_pkt", 64'(bus.pkt_out), 0);
    chk("mr_gnt", 64'(bus.gnt_in), 0);
    resetModel();
    @(negedge clk);
    reset = 1'b1;
    bus.req_in = 5'b00001;
    step();
    chk("mr_p0", 64'(bus.gnt_in), 64'(5'b00001));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      randPkts();
      bus.req_in  = 5'($urandom());
      bus.full_dn = ($urandom_range(0, 3) == 0);
      bus.gnt_dn  = ($urandom_range(0, 2) == 0);
      step();
      cyc = $countones(bus.gnt_in);
      chk("rnd_onehot", 64'(cyc <= 1), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
